// File: rtl/rsadd_seq_if.sv
// Control bundle between the FPU operation decoder / rsadd_cntl side and the
// RS microsequencer. The requester side drives the operation request and the
// datapath status; the sequencer drives the per-cycle datapath controls.
interface rsadd_seq_if;
   logic       fpuhold;
   logic       start;
   logic [1:0] op;
   logic [2:0] alncnt;
   logic       kill;
   logic       rsneg;
   logic       rs2zero;
   logic [2:0] rsfunc;
   logic [2:0] incinfunc;
   logic       rs32;
   logic       eadd;
   logic       busy;
   logic       done;
   logic       zres;

   modport master (
      output fpuhold, start, op, alncnt, kill, rsneg, rs2zero,
      input  rsfunc, incinfunc, rs32, eadd, busy, done, zres
   );

   modport slave (
      input  fpuhold, start, op, alncnt, kill, rsneg, rs2zero,
      output rsfunc, incinfunc, rs32, eadd, busy, done, zres
   );
endinterface

// File: rtl/rsadd_seq.sv
// Microsequencer for the FPU right-shift/add datapath. Steps one add/subtract
// through load, alignment, add, normalize, round and increment, driving the
// rsadd_cntl function selects as a Moore decode of the current state.
module rsadd_seq (
   input  logic         clk,
   input  logic         reset,
   rsadd_seq_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ALIGN = 3'd2,
      ADD   = 3'd3,
      NORM  = 3'd4,
      ROUND = 3'd5,
      INC   = 3'd6,
      DONE  = 3'd7
   } state_t;

   state_t     st_q, st_d;
   logic [2:0] cnt_q, cnt_d;
   logic [1:0] op_q, op_d;
   logic       neg_q, neg_d;
   logic       zero_q, zero_d;

   // State register; reset also forgets the last operation type
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q   <= IDLE;
         cnt_q  <= 3'd0;
         op_q   <= 2'd0;
         neg_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         neg_q  <= neg_d;
         zero_q <= zero_d;
      end
   end

   // Next-state logic: kill beats the stall, the stall freezes everything
   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      neg_d  = neg_q;
      zero_d = zero_q;
      if (bus.kill) begin
         st_d   = IDLE;
         cnt_d  = 3'd0;
         neg_d  = 1'b0;
         zero_d = 1'b0;
      end else if (!bus.fpuhold) begin
         case (st_q)
            IDLE: begin
               if (bus.start) begin
                  st_d  = LOAD;
                  cnt_d = bus.alncnt;
                  op_d  = bus.op;
               end
            end
            LOAD: begin
               st_d = (cnt_q != 3'd0) ? ALIGN : ADD;
            end
            ALIGN: begin
               if (cnt_q != 3'd0) begin
                  cnt_d = cnt_q - 3'd1;
               end
               if (cnt_q <= 3'd1) begin
                  st_d = ADD;
               end
            end
            ADD: begin
               st_d  = NORM;
               neg_d = ~bus.rsneg;
            end
            NORM: begin
               st_d = ROUND;
            end
            ROUND: begin
               st_d   = INC;
               zero_d = bus.rs2zero;
            end
            INC: begin
               st_d = DONE;
            end
            DONE: begin
               if (bus.start) begin
                  st_d  = LOAD;
                  cnt_d = bus.alncnt;
                  op_d  = bus.op;
               end else begin
                  st_d = IDLE;
               end
            end
            default: begin
               st_d = IDLE;
            end
         endcase
      end
   end

   // Output decode from registered state; only done looks at the stall input
   always_comb begin
      bus.rsfunc    = 3'h0;
      bus.incinfunc = 3'h0;
      bus.rs32      = 1'b0;
      bus.eadd      = ~op_q[1];
      bus.busy      = 1'b1;
      bus.done      = 1'b0;
      bus.zres      = 1'b0;
      case (st_q)
         IDLE: begin
            bus.eadd = 1'b1;
            bus.busy = 1'b0;
         end
         LOAD: begin
            bus.rsfunc = 3'h1;
         end
         ALIGN: begin
            bus.rsfunc = 3'h6;
            bus.rs32   = (cnt_q > 3'd1);
         end
         ADD: begin
            bus.rsfunc = 3'h3;
         end
         NORM: begin
            bus.rsfunc = neg_q ? 3'h7 : 3'h2;
         end
         ROUND: begin
            bus.rsfunc    = 3'h5;
            bus.incinfunc = {2'b01, op_q[0]};
         end
         INC: begin
            bus.rsfunc    = 3'h2;
            bus.incinfunc = 3'h6;
         end
         DONE: begin
            bus.done = ~bus.fpuhold;
            bus.zres = zero_q;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rsadd_seq.sv
// Scoreboard bench for rsadd_seq. Each operation's expected per-cycle output
// stream is built from the cycle-by-cycle latency description and queued when
// start is driven; every cycle pops one entry and compares it on the falling edge.
module tb_rsadd_seq;

   typedef logic [10:0] obs_t;

   logic clk = 1'b0;
   logic reset;
   rsadd_seq_if bus();

   rsadd_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   obs_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   // Packs {rsfunc, incinfunc, rs32, eadd, busy, done, zres}
   function automatic obs_t mk(input logic [2:0] rsf, input logic [2:0] inc,
                               input logic r32, input logic ea, input logic bsy,
                               input logic dn, input logic zr);
      return {rsf, inc, r32, ea, bsy, dn, zr};
   endfunction

   function automatic obs_t sampleDut();
      return {bus.rsfunc, bus.incinfunc, bus.rs32, bus.eadd, bus.busy, bus.done, bus.zres};
   endfunction

   // Counts one comparison and reports it if it disagrees
   task automatic checkOutput(input string tag, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s rsf/inc/rs32/eadd/busy/done/zres got %b_%b_%b%b%b%b%b required %b_%b_%b%b%b%b%b",
                  tag, got[10:8], got[7:5], got[4], got[3], got[2], got[1], got[0],
                  exp[10:8], exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Waits for the falling edge and compares against the oldest queued entry
   task automatic checkCycle(input string tag);
      obs_t exp;
      @(negedge clk);
      exp = (expQ.size() != 0) ? expQ.pop_front() : mk(3'h0, 3'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput(tag, sampleDut(), exp);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.start   = 1'b0;
         bus.fpuhold = 1'b0;
         bus.kill    = 1'b0;
         reset       = 1'b0;
         expQ.push_back(mk(3'h0, 3'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
         checkCycle($sformatf("idle%0d", i));
      end
   endtask

   // Called on a falling edge while the DUT sits in IDLE or DONE; starts one
   // operation, optionally stalls at cycle holdAt for holdLen cycles (with a
   // spurious start during the stall if junkStart), and optionally aborts
   // with kill or reset asserted during cycle abortAt.
   task automatic applyStimulus(input string name, input logic [1:0] op, input int aln,
                                input logic neg, input logic zer,
                                input int holdAt, input int holdLen,
                                input int abortAt, input bit abortRst, input bit junkStart);
      obs_t base[$];
      obs_t seq[$];
      logic e;
      bit   hold;
      e = ~op[1];
      base.push_back(mk(3'h1, 3'h0, 1'b0, e, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < aln; i++) begin
         base.push_back(mk(3'h6, 3'h0, (aln - i) > 1, e, 1'b1, 1'b0, 1'b0));
      end
      base.push_back(mk(3'h3, 3'h0, 1'b0, e, 1'b1, 1'b0, 1'b0));
      base.push_back(mk(neg ? 3'h2 : 3'h7, 3'h0, 1'b0, e, 1'b1, 1'b0, 1'b0));
      base.push_back(mk(3'h5, {2'b01, op[0]}, 1'b0, e, 1'b1, 1'b0, 1'b0));
      base.push_back(mk(3'h2, 3'h6, 1'b0, e, 1'b1, 1'b0, 1'b0));
      base.push_back(mk(3'h0, 3'h0, 1'b0, e, 1'b1, 1'b1, zer));
      for (int k = 0; k < base.size(); k++) begin
         if (k + 1 == holdAt) begin
            for (int h = 0; h < holdLen; h++) begin
               seq.push_back(base[k] & ~11'b000_0000_0010);
            end
         end
         seq.push_back(base[k]);
      end
      if (abortAt > 0) begin
         while (seq.size() > abortAt) begin
            void'(seq.pop_back());
         end
         seq.push_back(mk(3'h0, 3'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      end
      bus.start   = 1'b1;
      bus.op      = op;
      bus.alncnt  = 3'(aln);
      bus.rsneg   = neg;
      bus.rs2zero = zer;
      bus.fpuhold = 1'b0;
      bus.kill    = 1'b0;
      foreach (seq[k]) expQ.push_back(seq[k]);
      for (int c = 1; c <= seq.size(); c++) begin
         @(posedge clk);
         #1;
         hold        = (holdLen > 0) && (c >= holdAt) && (c < holdAt + holdLen);
         bus.fpuhold = hold;
         bus.start   = junkStart && hold;
         bus.kill    = (c == abortAt) && !abortRst;
         reset       = (c == abortAt) && abortRst;
         checkCycle($sformatf("%s c%0d", name, c));
      end
   endtask

   // Bounds the whole run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] timeout");
   end

   // Main sequence
   initial begin
      reset       = 1'b1;
      bus.fpuhold = 1'b0;
      bus.start   = 1'b0;
      bus.op      = 2'd0;
      bus.alncnt  = 3'd0;
      bus.kill    = 1'b0;
      bus.rsneg   = 1'b1;
      bus.rs2zero = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         expQ.push_back(mk(3'h0, 3'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
         checkCycle("reset");
      end
      idleCycles(1);

      $display("[TB] single add alncnt=2");
      applyStimulus("add", 2'd0, 2, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      idleCycles(1);

      $display("[TB] double subtract with negate, back-to-back zero result");
      applyStimulus("subneg", 2'd3, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus("zero", 2'd1, 3, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0);
      idleCycles(2);

      $display("[TB] stall in ALIGN then start in DONE");
      applyStimulus("stall", 2'd2, 7, 1'b1, 1'b0, 3, 3, 0, 1'b0, 1'b1);
      applyStimulus("chain", 2'd0, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      idleCycles(1);

      $display("[TB] stall in DONE with ignored start");
      applyStimulus("dstall", 2'd0, 0, 1'b1, 1'b1, 6, 2, 0, 1'b0, 1'b1);
      idleCycles(1);

      $display("[TB] kill and reset mid-operation");
      applyStimulus("killrnd", 2'd1, 2, 1'b1, 1'b1, 6, 1, 6, 1'b0, 1'b0);
      idleCycles(2);
      applyStimulus("rstaln", 2'd3, 4, 1'b1, 1'b0, 0, 0, 3, 1'b1, 1'b0);
      idleCycles(1);
      applyStimulus("killld", 2'd2, 5, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0);
      idleCycles(1);
      applyStimulus("after", 2'd2, 1, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
      idleCycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
